// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_pkg: shared widths, source indices and request type for the writeback arbiter
package rf_wb_pkg;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_MDU = 2;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: valid/ready writeback source bundle, one lane per source
//   src_valid  source i presents a write request
//   src_addr   dest register of source i at [i*ADDR_W +: ADDR_W]
//   src_data   write data of source i at [i*DATA_W +: DATA_W]
//   src_ready  buffer i can accept this cycle
interface rf_wb_arbiter_if import rf_wb_pkg::*; #(parameter int NUM_SRC = 3) ();
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    modport master (output src_valid, output src_addr, output src_data, input src_ready);
    modport slave (input src_valid, input src_addr, input src_data, output src_ready);
endinterface

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant over req_i starting at ptr_i
//   req_i       request vector
//   ptr_i       highest-priority index this cycle
//   grant_o     one-hot grant (zero when no request)
//   next_ptr_o  index after the granted one, or ptr_i when nothing is granted
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] next_ptr_o
);
    always_comb begin
        int idx;
        logic found;
        grant_o    = '0;
        next_ptr_o = ptr_i;
        found      = 1'b0;
        idx        = 0;
        for (int o = 0; o < N; o++) begin
            idx = (int'(ptr_i) + o) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                next_ptr_o   = PW'((idx + 1) % N);
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among NUM_SRC buffered writeback sources
//   clk_i, rst_i           clock, synchronous active-high reset
//   src                    per-source valid/ready request lanes (slave side)
//   RegWrite_o/RDaddr_o/RDdata_o  registered write port to Reg_File
//   RSaddr_i/RTaddr_i      read addresses checked against pending writes
//   rs_hazard_o/rt_hazard_o  read register still has an uncommitted write
//   busy_o                 any buffer full or write stage active
module rf_wb_arbiter import rf_wb_pkg::*; #(
    parameter int NUM_SRC = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rf_wb_arbiter_if.slave    src,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic              rs_hazard_o,
    output logic              rt_hazard_o,
    output logic              busy_o
);
    localparam int PW = $clog2(NUM_SRC);
    wb_req_t             buf_q [NUM_SRC];
    logic [NUM_SRC-1:0]  full_q, grant, accept;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                we_q;
    logic [ADDR_W-1:0]   wa_q;
    logic [DATA_W-1:0]   wd_q;
    wb_req_t             sel;
    logic                rs_pend, rt_pend;
    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req_i      (full_q),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .next_ptr_o (ptr_d)
    );
    // A buffer being drained this cycle can be refilled at the same edge.
    assign src.src_ready = ~full_q | grant;
    assign accept        = src.src_valid & src.src_ready;
    always_comb begin
        sel     = '0;
        rs_pend = we_q && wa_q == RSaddr_i;
        rt_pend = we_q && wa_q == RTaddr_i;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) sel = buf_q[i];
            if (full_q[i] && buf_q[i].addr == RSaddr_i) rs_pend = 1'b1;
            if (full_q[i] && buf_q[i].addr == RTaddr_i) rt_pend = 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= '0;
            ptr_q  <= '0;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    full_q[i] <= 1'b1;
                    buf_q[i]  <= '{addr: src.src_addr[i*ADDR_W +: ADDR_W], data: src.src_data[i*DATA_W +: DATA_W]};
                end else if (grant[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
            ptr_q <= ptr_d;
            // r0 writes are drained like any other but never strobe the register file.
            we_q  <= |grant && sel.addr != '0;
            if (|grant) begin
                wa_q <= sel.addr;
                wd_q <= sel.data;
            end
        end
    end
    assign RegWrite_o  = we_q;
    assign RDaddr_o    = wa_q;
    assign RDdata_o    = wd_q;
    assign rs_hazard_o = rs_pend && RSaddr_i != '0;
    assign rt_hazard_o = rt_pend && RTaddr_i != '0;
    assign busy_o      = |full_q || we_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;
    localparam int NS = 3;
    logic clk = 1'b0;
    logic rst_i;
    logic regwrite, rs_hz, rt_hz, busy;
    logic [ADDR_W-1:0] rdaddr, rsaddr, rtaddr;
    logic [DATA_W-1:0] rddata;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    rf_wb_arbiter_if #(.NUM_SRC(NS)) bus ();
    rf_wb_arbiter #(.NUM_SRC(NS)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .src         (bus.slave),
        .RegWrite_o  (regwrite),
        .RDaddr_o    (rdaddr),
        .RDdata_o    (rddata),
        .RSaddr_i    (rsaddr),
        .RTaddr_i    (rtaddr),
        .rs_hazard_o (rs_hz),
        .rt_hazard_o (rt_hz),
        .busy_o      (busy)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(int s, logic v, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        bus.src_valid[s]                = v;
        bus.src_addr[s*ADDR_W +: ADDR_W] = a;
        bus.src_data[s*DATA_W +: DATA_W] = d;
    endtask
    task automatic idle_all();
        for (int s = 0; s < NS; s++) drive(s, 1'b0, '0, '0);
    endtask
    task automatic pulse_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
    endtask
    task automatic test_reset();
        idle_all();
        rsaddr = 5'd5;
        rtaddr = 5'd7;
        rst_i  = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if (regwrite !== 1'b0 || rdaddr !== '0 || rddata !== '0) begin
            errors++;
            $display("FAIL reset_wport got we=%b a=%0d d=%h expected 0 0 0", regwrite, rdaddr, rddata);
        end
        checks++;
        if (bus.src_ready !== 3'b111 || busy !== 1'b0 || rs_hz !== 1'b0 || rt_hz !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got ready=%b busy=%b rs=%b rt=%b expected 111 0 0 0", bus.src_ready, busy, rs_hz, rt_hz);
        end
    endtask
    task automatic test_alu_single();
        rsaddr = 5'd5;
        drive(SRC_ALU, 1'b1, 5'd5, 32'h1234);
        tick();
        idle_all();
        #1;
        checks++;
        if (rs_hz !== 1'b1 || busy !== 1'b1 || regwrite !== 1'b0) begin
            errors++;
            $display("FAIL alu_buffered got rs=%b busy=%b we=%b expected 1 1 0", rs_hz, busy, regwrite);
        end
        tick();
        checks++;
        if (regwrite !== 1'b1 || rdaddr !== 5'd5 || rddata !== 32'h1234 || rs_hz !== 1'b1) begin
            errors++;
            $display("FAIL alu_write got we=%b a=%0d d=%h rs=%b expected 1 5 1234 1", regwrite, rdaddr, rddata, rs_hz);
        end
        tick();
        checks++;
        if (regwrite !== 1'b0 || rs_hz !== 1'b0 || busy !== 1'b0 || rdaddr !== 5'd5) begin
            errors++;
            $display("FAIL alu_done got we=%b rs=%b busy=%b a=%0d expected 0 0 0 5", regwrite, rs_hz, busy, rdaddr);
        end
    endtask
    task automatic test_three_sources();
        logic [ADDR_W-1:0] ea [3] = '{5'd3, 5'd4, 5'd6};
        logic [DATA_W-1:0] ed [3] = '{32'hA, 32'hB, 32'hC};
        logic [NS-1:0]     er [3] = '{3'b011, 3'b111, 3'b111};
        pulse_reset();
        drive(SRC_ALU, 1'b1, 5'd3, 32'hA);
        drive(SRC_MEM, 1'b1, 5'd4, 32'hB);
        drive(SRC_MDU, 1'b1, 5'd6, 32'hC);
        tick();
        idle_all();
        #1;
        checks++;
        if (bus.src_ready !== 3'b001) begin
            errors++;
            $display("FAIL three_ready0 got %b expected 001", bus.src_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (regwrite !== 1'b1 || rdaddr !== ea[k] || rddata !== ed[k] || bus.src_ready !== er[k]) begin
                errors++;
                $display("FAIL three_order%0d got we=%b a=%0d d=%h ready=%b expected 1 %0d %h %b", k, regwrite, rdaddr, rddata, bus.src_ready, ea[k], ed[k], er[k]);
            end
        end
        tick();
        checks++;
        if (regwrite !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL three_drain got we=%b busy=%b expected 0 0", regwrite, busy);
        end
    endtask
    task automatic test_same_reg();
        logic [DATA_W-1:0] ed [2] = '{32'h1, 32'h2};
        rtaddr = 5'd7;
        drive(SRC_ALU, 1'b1, 5'd7, 32'h1);
        drive(SRC_MEM, 1'b1, 5'd7, 32'h2);
        tick();
        idle_all();
        #1;
        checks++;
        if (rt_hz !== 1'b1) begin
            errors++;
            $display("FAIL same_hz0 got %b expected 1", rt_hz);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (regwrite !== 1'b1 || rdaddr !== 5'd7 || rddata !== ed[k] || rt_hz !== 1'b1) begin
                errors++;
                $display("FAIL same_write%0d got we=%b a=%0d d=%h rt=%b expected 1 7 %h 1", k, regwrite, rdaddr, rddata, rt_hz, ed[k]);
            end
        end
        tick();
        checks++;
        if (regwrite !== 1'b0 || rt_hz !== 1'b0) begin
            errors++;
            $display("FAIL same_clear got we=%b rt=%b expected 0 0", regwrite, rt_hz);
        end
    endtask
    task automatic test_r0();
        rsaddr = 5'd0;
        rtaddr = 5'd0;
        drive(SRC_MDU, 1'b1, 5'd0, 32'hFFFF);
        #1;
        checks++;
        if (bus.src_ready[SRC_MDU] !== 1'b1) begin
            errors++;
            $display("FAIL r0_ready got %b expected 1", bus.src_ready[SRC_MDU]);
        end
        tick();
        idle_all();
        #1;
        checks++;
        if (rs_hz !== 1'b0 || rt_hz !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL r0_buffered got rs=%b rt=%b busy=%b expected 0 0 1", rs_hz, rt_hz, busy);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (regwrite !== 1'b0 || busy !== 1'b0 || bus.src_ready !== 3'b111) begin
                errors++;
                $display("FAIL r0_drop%0d got we=%b busy=%b ready=%b expected 0 0 111", k, regwrite, busy, bus.src_ready);
            end
        end
    endtask
    task automatic test_reset_flush();
        rsaddr = 5'd10;
        rtaddr = 5'd11;
        drive(SRC_ALU, 1'b1, 5'd10, 32'h10);
        drive(SRC_MEM, 1'b1, 5'd11, 32'h11);
        drive(SRC_MDU, 1'b1, 5'd12, 32'h12);
        tick();
        idle_all();
        #1;
        checks++;
        if (bus.src_ready !== 3'b001 || rs_hz !== 1'b1 || rt_hz !== 1'b1) begin
            errors++;
            $display("FAIL flush_full got ready=%b rs=%b rt=%b expected 001 1 1", bus.src_ready, rs_hz, rt_hz);
        end
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (regwrite !== 1'b0 || busy !== 1'b0 || bus.src_ready !== 3'b111 || rs_hz !== 1'b0 || rt_hz !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty%0d got we=%b busy=%b ready=%b rs=%b rt=%b expected 0 0 111 0 0", k, regwrite, busy, bus.src_ready, rs_hz, rt_hz);
            end
            tick();
        end
        drive(SRC_ALU, 1'b1, 5'd2, 32'h55);
        drive(SRC_MEM, 1'b1, 5'd9, 32'h99);
        tick();
        idle_all();
        tick();
        checks++;
        if (regwrite !== 1'b1 || rdaddr !== 5'd2 || rddata !== 32'h55) begin
            errors++;
            $display("FAIL flush_after got we=%b a=%0d d=%h expected 1 2 55", regwrite, rdaddr, rddata);
        end
        tick();
        tick();
    endtask
    task automatic test_random();
        bit                m_full [NS];
        logic [ADDR_W-1:0] m_a [NS];
        logic [DATA_W-1:0] m_d [NS];
        bit                o_v [NS];
        logic [ADDR_W-1:0] o_a [NS];
        logic [DATA_W-1:0] o_d [NS];
        int                m_ptr, g;
        bit                m_we, e_rs, e_rt, e_busy;
        logic [ADDR_W-1:0] m_wa;
        logic [DATA_W-1:0] m_wd;
        logic [NS-1:0]     er;
        pulse_reset();
        m_ptr = 0;
        m_we  = 1'b0;
        m_wa  = '0;
        m_wd  = '0;
        for (int i = 0; i < NS; i++) begin
            m_full[i] = 1'b0;
            o_v[i]    = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (!o_v[i] && $urandom_range(1, 0) == 1) begin
                    o_v[i] = 1'b1;
                    o_a[i] = 5'($urandom_range(7, 0));
                    o_d[i] = $urandom;
                end
                drive(i, o_v[i], o_v[i] ? o_a[i] : '0, o_v[i] ? o_d[i] : '0);
            end
            rsaddr = 5'($urandom_range(7, 0));
            rtaddr = 5'($urandom_range(7, 0));
            #1;
            g = -1;
            for (int o = 0; o < NS; o++)
                if (g < 0 && m_full[(m_ptr + o) % NS]) g = (m_ptr + o) % NS;
            e_rs   = rsaddr != 0 && m_we && m_wa == rsaddr;
            e_rt   = rtaddr != 0 && m_we && m_wa == rtaddr;
            e_busy = m_we;
            for (int i = 0; i < NS; i++) begin
                er[i] = !m_full[i] || g == i;
                if (m_full[i]) e_busy = 1'b1;
                if (m_full[i] && rsaddr != 0 && m_a[i] == rsaddr) e_rs = 1'b1;
                if (m_full[i] && rtaddr != 0 && m_a[i] == rtaddr) e_rt = 1'b1;
            end
            checks++;
            if (regwrite !== m_we || rdaddr !== m_wa || rddata !== m_wd) begin
                errors++;
                $display("FAIL rand_wport c=%0d got we=%b a=%0d d=%h expected %b %0d %h", c, regwrite, rdaddr, rddata, m_we, m_wa, m_wd);
            end
            checks++;
            if (bus.src_ready !== er || rs_hz !== e_rs || rt_hz !== e_rt || busy !== e_busy) begin
                errors++;
                $display("FAIL rand_status c=%0d got ready=%b rs=%b rt=%b busy=%b expected %b %b %b %b", c, bus.src_ready, rs_hz, rt_hz, busy, er, e_rs, e_rt, e_busy);
            end
            if (g >= 0) begin
                m_we  = m_a[g] != 0;
                m_wa  = m_a[g];
                m_wd  = m_d[g];
                m_ptr = (g + 1) % NS;
            end else begin
                m_we = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
                if (o_v[i] && er[i]) begin
                    m_full[i] = 1'b1;
                    m_a[i]    = o_a[i];
                    m_d[i]    = o_d[i];
                    o_v[i]    = 1'b0;
                end else if (g == i) begin
                    m_full[i] = 1'b0;
                end
            end
            tick();
        end
        idle_all();
    endtask
    initial begin
        rst_i  = 1'b1;
        rsaddr = '0;
        rtaddr = '0;
        idle_all();
        test_reset();
        test_alu_single();
        test_three_sources();
        test_same_reg();
        test_r0();
        test_reset_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
